// File: rtl/mem_burst_reader.sv
// rtl/mem_burst_reader.sv - reads a burst of consecutive words from a 1-cycle-latency memory onto a valid/ready stream.
// Optional READ_CHECKSUM_EN adds a running XOR checksum of delivered words.
module mem_burst_reader #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
`ifdef READ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0]   REM_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_addr;
  logic [ADDR_W:0]     r_rem;
  logic [DATA_W-1:0]   r_out_data;
  logic                r_out_valid;
  logic                r_out_last;
  logic                w_handshake;
  logic                w_last_word;

  assign w_handshake = r_out_valid & out_ready;
  assign w_last_word = (r_rem == REM_ONE);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (count == '0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  w_next = S_HOLD;
      S_HOLD: begin
        if (w_handshake) begin
          w_next = w_last_word ? S_DONE : S_ISSUE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (res) begin
      r_state     <= S_IDLE;
      r_addr      <= '0;
      r_rem       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start && (count != '0)) begin
            r_addr <= base_addr;
            r_rem  <= count;
          end
        end
        S_WAIT: begin
          r_out_data  <= mem_rdata;
          r_out_valid <= 1'b1;
          r_out_last  <= w_last_word;
        end
        S_HOLD: begin
          if (w_handshake) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_rem       <= r_rem - REM_ONE;
            if (!w_last_word) begin
              r_addr <= r_addr + ADDR_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef READ_CHECKSUM_EN
  logic [DATA_W-1:0] r_checksum;

  // Cleared by any start taken in IDLE, including a zero-length burst.
  always_ff @(posedge clk) begin
    if (res) begin
      r_checksum <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      r_checksum <= '0;
    end else if ((r_state == S_HOLD) && w_handshake) begin
      r_checksum <= r_checksum ^ r_out_data;
    end
  end

  assign checksum = r_checksum;
`endif

  assign mem_rd_en = (r_state == S_ISSUE);
  assign mem_addr  = r_addr;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);

endmodule
